// File: rtl/lcd_pkg.sv
// Shared types and DDRAM address-space helpers for the HD44780-style responder.
package lcd_pkg;

  typedef enum logic [1:0] {SWEEP, IDLE, E_HIGH, EXEC} lcd_state_e;

  typedef struct packed {
    logic       rs;
    logic [7:0] d;
  } lcd_wr_t;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;
  localparam logic [7:0] CMD_ENTRY = 8'h04;
  localparam logic [7:0] CMD_DISP  = 8'h08;
  localparam logic [7:0] CMD_SHIFT = 8'h10;
  localparam logic [7:0] CMD_FUNC  = 8'h20;
  localparam logic [7:0] CMD_CGRAM = 8'h40;
  localparam logic [7:0] CMD_DDRAM = 8'h80;

  localparam logic [6:0] LINE1_BASE = 7'h00;
  localparam logic [6:0] LINE2_BASE = 7'h40;
  localparam int         LINE_LEN   = 40;
  localparam int         DDRAM_SIZE = 80;
  localparam logic [7:0] BLANK      = 8'h20;

  localparam logic [6:0] LINE1_LAST = LINE1_BASE + 7'(LINE_LEN) - 7'd1;
  localparam logic [6:0] LINE2_LAST = LINE2_BASE + 7'(LINE_LEN) - 7'd1;
  localparam logic [6:0] ONE_LAST   = 7'(DDRAM_SIZE) - 7'd1;

  function automatic logic addr_valid(input logic [6:0] a, input logic two);
    if (two) return (a <= LINE1_LAST) || (a >= LINE2_BASE && a <= LINE2_LAST);
    return a <= ONE_LAST;
  endfunction

  function automatic logic [6:0] addr_to_idx(input logic [6:0] a, input logic two);
    if (two && a >= LINE2_BASE) return a - LINE2_BASE + 7'(LINE_LEN);
    return a;
  endfunction

  // Address counter step with the line-to-line wrap of the real controller.
  function automatic logic [6:0] addr_step(input logic [6:0] a, input logic up, input logic two);
    if (two) begin
      if (up && a == LINE1_LAST) return LINE2_BASE;
      if (up && a == LINE2_LAST) return LINE1_BASE;
      if (!up && a == LINE1_BASE) return LINE2_LAST;
      if (!up && a == LINE2_BASE) return LINE1_LAST;
    end else begin
      if (up && a == ONE_LAST) return LINE1_BASE;
      if (!up && a == LINE1_BASE) return ONE_LAST;
    end
    return up ? a + 7'd1 : a - 7'd1;
  endfunction

endpackage

// File: rtl/lcd_ddram.sv
// 80x8 display RAM: one synchronous write port, one registered read port on storage index.
module lcd_ddram
  import lcd_pkg::*;
(
  input  logic       clock,
  input  logic       we,
  input  logic [6:0] waddr,
  input  logic [7:0] wdata,
  input  logic [6:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] mem_q [DDRAM_SIZE];
  logic [7:0] rdata_q;

  always_ff @(posedge clock) begin
    if (we && waddr < 7'(DDRAM_SIZE)) mem_q[waddr] <= wdata;
    rdata_q <= (raddr < 7'(DDRAM_SIZE)) ? mem_q[raddr] : BLANK;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/lcd_responder.sv
// Receiving end of the RS/E/D LCD write bus: decodes bytes on E falling edge,
// keeps DDRAM and display state, models busy time and flags bus-timing violations.
module lcd_responder
  import lcd_pkg::*;
#(
  parameter int EXEC_CYCLES  = 2000,
  parameter int CLEAR_CYCLES = 76500,
  parameter int MIN_E_HIGH   = 12
) (
  input  logic       clock,
  input  logic       internal_reset,
  input  logic       rs,
  input  logic       e,
  input  logic [7:0] d,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       cmd_valid,
  output logic       data_valid,
  output logic [7:0] last_byte,
  output logic [6:0] cursor_addr,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       inc_mode,
  output logic       shift_mode,
  output logic       two_line,
  output logic       violation
);

  lcd_state_e  state_q, state_d;
  logic        e_q, e_d, e_prev_q, e_prev_d;
  lcd_wr_t     bus_q, bus_d, cap_q, cap_d;
  logic [15:0] ecnt_q, ecnt_d;
  logic [31:0] xcnt_q, xcnt_d;
  logic [6:0]  swp_q, swp_d, cursor_q, cursor_d;
  logic        clr_q, clr_d, cmd_valid_q, cmd_valid_d, data_valid_q, data_valid_d;
  logic [7:0]  last_byte_q, last_byte_d;
  logic        disp_q, disp_d, cur_q, cur_d, blink_q, blink_d;
  logic        inc_q, inc_d, shift_q, shift_d, two_q, two_d, viol_q, viol_d;
  logic        rd_inv_q, rd_inv_d;

  logic        fall, rise, we;
  logic [6:0]  widx;
  logic [7:0]  wdata, cmd, ram_rdata;

  assign fall = e_prev_q & ~e_q;
  assign rise = e_q & ~e_prev_q;
  assign cmd  = cap_q.d;

  always_comb begin
    state_d      = state_q;
    e_d          = e;
    e_prev_d     = e_q;
    bus_d        = '{rs: rs, d: d};
    cap_d        = e_q ? bus_q : cap_q;
    ecnt_d       = ecnt_q;
    xcnt_d       = xcnt_q;
    swp_d        = swp_q;
    clr_d        = clr_q;
    cmd_valid_d  = 1'b0;
    data_valid_d = 1'b0;
    last_byte_d  = last_byte_q;
    cursor_d     = cursor_q;
    disp_d       = disp_q;
    cur_d        = cur_q;
    blink_d      = blink_q;
    inc_d        = inc_q;
    shift_d      = shift_q;
    two_d        = two_q;
    viol_d       = viol_q;
    rd_inv_d     = !addr_valid(rd_addr, two_q);
    we           = 1'b0;
    widx         = swp_q;
    wdata        = BLANK;

    case (state_q)
      SWEEP: begin
        we = 1'b1;
        if (fall) viol_d = 1'b1;
        if (swp_q == 7'(DDRAM_SIZE - 1)) begin
          swp_d   = '0;
          state_d = IDLE;
        end else begin
          swp_d = swp_q + 7'd1;
        end
      end

      IDLE: begin
        if (rise) begin
          ecnt_d  = 16'd1;
          state_d = E_HIGH;
        end
      end

      E_HIGH: begin
        if (e_q) begin
          if (ecnt_q != '1) ecnt_d = ecnt_q + 16'd1;
        end else if (ecnt_q < 16'(MIN_E_HIGH)) begin
          viol_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d     = EXEC;
          last_byte_d = cap_q.d;
          xcnt_d      = 32'(EXEC_CYCLES - 1);
          if (cap_q.rs) begin
            data_valid_d = 1'b1;
            if (addr_valid(cursor_q, two_q)) begin
              we    = 1'b1;
              widx  = addr_to_idx(cursor_q, two_q);
              wdata = cap_q.d;
            end
            cursor_d = addr_step(cursor_q, inc_q, two_q);
          end else begin
            cmd_valid_d = 1'b1;
            // Highest set bit selects the instruction.
            if (|(cmd & CMD_DDRAM)) begin
              if (addr_valid(cmd[6:0], two_q)) cursor_d = cmd[6:0];
              else begin
                cursor_d = LINE1_BASE;
                viol_d   = 1'b1;
              end
            end else if (|(cmd & CMD_CGRAM)) begin
              cursor_d = cursor_q;
            end else if (|(cmd & CMD_FUNC)) begin
              two_d = cmd[3];
            end else if (|(cmd & CMD_SHIFT)) begin
              if (!cmd[3]) cursor_d = addr_step(cursor_q, cmd[2], two_q);
            end else if (|(cmd & CMD_DISP)) begin
              disp_d  = cmd[2];
              cur_d   = cmd[1];
              blink_d = cmd[0];
            end else if (|(cmd & CMD_ENTRY)) begin
              inc_d   = cmd[1];
              shift_d = cmd[0];
            end else if (|(cmd & CMD_HOME)) begin
              cursor_d = LINE1_BASE;
              xcnt_d   = 32'(CLEAR_CYCLES - 1);
            end else if (|(cmd & CMD_CLEAR)) begin
              cursor_d = LINE1_BASE;
              inc_d    = 1'b1;
              clr_d    = 1'b1;
              swp_d    = '0;
              xcnt_d   = 32'(CLEAR_CYCLES - 1);
            end
          end
        end
      end

      EXEC: begin
        if (fall) viol_d = 1'b1;
        // Clear blanks one cell per cycle at the start of its busy window.
        if (clr_q) begin
          we = 1'b1;
          if (swp_q == 7'(DDRAM_SIZE - 1)) begin
            swp_d = '0;
            clr_d = 1'b0;
          end else begin
            swp_d = swp_q + 7'd1;
          end
        end
        if (xcnt_q == '0) state_d = IDLE;
        else xcnt_d = xcnt_q - 32'd1;
      end

      default: state_d = SWEEP;
    endcase
  end

  always_ff @(posedge clock) begin
    if (internal_reset) begin
      state_q      <= SWEEP;
      e_q          <= 1'b0;
      e_prev_q     <= 1'b0;
      bus_q        <= '0;
      cap_q        <= '0;
      ecnt_q       <= '0;
      xcnt_q       <= '0;
      swp_q        <= '0;
      clr_q        <= 1'b0;
      cmd_valid_q  <= 1'b0;
      data_valid_q <= 1'b0;
      last_byte_q  <= 8'h00;
      cursor_q     <= '0;
      disp_q       <= 1'b0;
      cur_q        <= 1'b0;
      blink_q      <= 1'b0;
      inc_q        <= 1'b1;
      shift_q      <= 1'b0;
      two_q        <= 1'b0;
      viol_q       <= 1'b0;
      rd_inv_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      e_q          <= e_d;
      e_prev_q     <= e_prev_d;
      bus_q        <= bus_d;
      cap_q        <= cap_d;
      ecnt_q       <= ecnt_d;
      xcnt_q       <= xcnt_d;
      swp_q        <= swp_d;
      clr_q        <= clr_d;
      cmd_valid_q  <= cmd_valid_d;
      data_valid_q <= data_valid_d;
      last_byte_q  <= last_byte_d;
      cursor_q     <= cursor_d;
      disp_q       <= disp_d;
      cur_q        <= cur_d;
      blink_q      <= blink_d;
      inc_q        <= inc_d;
      shift_q      <= shift_d;
      two_q        <= two_d;
      viol_q       <= viol_d;
      rd_inv_q     <= rd_inv_d;
    end
  end

  lcd_ddram u_ddram (
    .clock (clock),
    .we    (we),
    .waddr (widx),
    .wdata (wdata),
    .raddr (addr_to_idx(rd_addr, two_q)),
    .rdata (ram_rdata)
  );

  assign rd_data     = rd_inv_q ? BLANK : ram_rdata;
  assign busy        = (state_q == SWEEP) || (state_q == EXEC);
  assign cmd_valid   = cmd_valid_q;
  assign data_valid  = data_valid_q;
  assign last_byte   = last_byte_q;
  assign cursor_addr = cursor_q;
  assign display_on  = disp_q;
  assign cursor_on   = cur_q;
  assign blink_on    = blink_q;
  assign inc_mode    = inc_q;
  assign shift_mode  = shift_q;
  assign two_line    = two_q;
  assign violation   = viol_q;

endmodule

// File: tb/tb_lcd_responder.sv
// Directed bench for lcd_responder; clear time scaled down to keep the run short.
module tb_lcd_responder;

  localparam int EXEC  = 2000;
  localparam int CLEAR = 7650;
  localparam int MIN_E = 12;

  logic       clock = 1'b0;
  logic       internal_reset, rs, e;
  logic [7:0] d;
  logic [6:0] rd_addr;
  logic [7:0] rd_data, last_byte;
  logic       busy, cmd_valid, data_valid;
  logic [6:0] cursor_addr;
  logic       display_on, cursor_on, blink_on, inc_mode, shift_mode, two_line, violation;

  int checks = 0;
  int errors = 0;

  lcd_responder #(.EXEC_CYCLES(EXEC), .CLEAR_CYCLES(CLEAR), .MIN_E_HIGH(MIN_E)) dut (
    .clock(clock), .internal_reset(internal_reset), .rs(rs), .e(e), .d(d),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .cmd_valid(cmd_valid),
    .data_valid(data_valid), .last_byte(last_byte), .cursor_addr(cursor_addr),
    .display_on(display_on), .cursor_on(cursor_on), .blink_on(blink_on),
    .inc_mode(inc_mode), .shift_mode(shift_mode), .two_line(two_line), .violation(violation)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] flags();
    return {busy, cmd_valid, data_valid, display_on, cursor_on, blink_on,
            inc_mode, shift_mode, two_line, violation};
  endfunction

  task automatic lcd_write(input logic r, input logic [7:0] b, input int hi);
    rs = r;
    d  = b;
    e  = 1'b1;
    tick(hi);
    e  = 1'b0;
  endtask

  task automatic busy_len(output int n, output int pulses);
    n = 0;
    pulses = 0;
    while (busy === 1'b1 && n < 20000) begin
      n++;
      pulses += int'(cmd_valid) + int'(data_valid);
      tick(1);
    end
  endtask

  task automatic rd(input logic [6:0] a, output logic [7:0] v);
    rd_addr = a;
    tick(1);
    v = rd_data;
  endtask

  task automatic do_write(input string tag, input logic r, input logic [7:0] b, input int exp_busy);
    int n, p;
    lcd_write(r, b, MIN_E);
    tick(1);
    chk({tag, "_prebusy"}, busy, 0);
    tick(1);
    chk({tag, "_valid"}, {cmd_valid, data_valid}, r ? 2'b01 : 2'b10);
    chk({tag, "_last"}, last_byte, b);
    busy_len(n, p);
    chk({tag, "_busy"}, n, exp_busy);
    chk({tag, "_pulses"}, p, 1);
  endtask

  task automatic count_nonblank(output int bad);
    logic [7:0] v;
    bad = 0;
    for (int a = 0; a < 80; a++) begin
      rd(7'(a), v);
      if (v !== 8'h20) bad++;
    end
  endtask

  initial begin
    logic [7:0] v;
    int n, m, p, bad;
    internal_reset = 1'b1;
    rs = 1'b0; e = 1'b0; d = 8'h00; rd_addr = 7'h00;
    tick(3);
    chk("rst_flags", flags(), 10'h208);
    chk("rst_last", last_byte, 8'h00);
    chk("rst_cursor", cursor_addr, 7'h00);

    internal_reset = 1'b0;
    busy_len(n, p);
    chk("sweep_busy", n, 80);
    chk("sweep_pulses", p, 0);
    count_nonblank(bad);
    chk("sweep_blank", bad, 0);
    chk("sweep_inc", inc_mode, 1);

    do_write("f38", 1'b0, 8'h38, EXEC);
    chk("two_line", two_line, 1);
    do_write("d0e", 1'b0, 8'h0E, EXEC);
    chk("disp_flags", {display_on, cursor_on, blink_on}, 3'b110);
    do_write("a27", 1'b0, 8'hA7, EXEC);
    chk("cur_27", cursor_addr, 7'h27);
    do_write("wA", 1'b1, 8'h41, EXEC);
    chk("cur_wrap40", cursor_addr, 7'h40);
    do_write("wB", 1'b1, 8'h42, EXEC);
    chk("cur_41", cursor_addr, 7'h41);
    rd(7'h27, v); chk("rd_27", v, 8'h41);
    rd(7'h40, v); chk("rd_40", v, 8'h42);
    rd(7'h28, v); chk("rd_inval28", v, 8'h20);
    chk("viol_clean", violation, 0);

    // 11-cycle E pulse must be rejected
    lcd_write(1'b1, 8'h55, MIN_E - 1);
    p = 0;
    repeat (4) begin tick(1); p += int'(cmd_valid) + int'(data_valid); end
    chk("short_pulses", p, 0);
    chk("short_viol", violation, 1);
    chk("short_busy", busy, 0);
    chk("short_cursor", cursor_addr, 7'h41);
    chk("short_last", last_byte, 8'h42);
    rd(7'h41, v); chk("short_ram", v, 8'h20);

    internal_reset = 1'b1;
    tick(2);
    internal_reset = 1'b0;
    busy_len(n, p);
    chk("rst2_busy", n, 80);
    chk("rst2_viol", violation, 0);

    // write issued during busy: ignored, countdown unchanged
    lcd_write(1'b0, 8'h06, MIN_E);
    tick(2);
    chk("bw_valid", cmd_valid, 1);
    n = 0;
    repeat (50) begin n += int'(busy); tick(1); end
    rs = 1'b0; d = 8'h0C; e = 1'b1;
    repeat (MIN_E) begin n += int'(busy); tick(1); end
    e = 1'b0;
    busy_len(m, p);
    n += m;
    chk("bw_busy", n, EXEC);
    chk("bw_pulses", p, 0);
    chk("bw_viol", violation, 1);
    chk("bw_disp", display_on, 0);

    do_write("e04", 1'b0, 8'h04, EXEC);
    chk("inc_off", inc_mode, 0);
    do_write("wZ", 1'b1, 8'h5A, EXEC);
    chk("cur_wrap4f", cursor_addr, 7'h4F);
    rd(7'h00, v); chk("rd_00", v, 8'h5A);
    do_write("ad0", 1'b0, 8'hD0, EXEC);
    chk("cur_inval", cursor_addr, 7'h00);
    do_write("s10", 1'b0, 8'h10, EXEC);
    chk("cur_shift", cursor_addr, 7'h4F);

    do_write("clr", 1'b0, 8'h01, CLEAR);
    chk("clr_cursor", cursor_addr, 7'h00);
    chk("clr_inc", inc_mode, 1);
    count_nonblank(bad);
    chk("clr_blank", bad, 0);

    // reset in the middle of a clear
    do_write("d0f", 1'b0, 8'h0F, EXEC);
    lcd_write(1'b0, 8'h01, MIN_E);
    tick(42);
    chk("mid_busy", busy, 1);
    internal_reset = 1'b1;
    tick(1);
    chk("mid_flags", flags(), 10'h208);
    chk("mid_last", last_byte, 8'h00);
    chk("mid_cursor", cursor_addr, 7'h00);
    internal_reset = 1'b0;
    busy_len(n, p);
    chk("mid_rel_busy", n, 80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
